regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32×64-bit integer register file. Two writeback sources share the file's single write port: the single-cycle ALU path (A) and the multi-cycle load/divide path (B). The block grants one source per cycle and registers the winning write onto the file's `writeReg`/`writeData`/`regWrite` inputs. It also prevents B starvation and suppresses architectural writes to x0.

## Interface
- `MAX_WAIT`, default 4: consecutive cycles B may be refused before it is force-granted; legal range 1–15.
- `XLEN`, default 64: data width.

- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `a_valid`, input, 1: ALU writeback request.
- `a_rd`, input, 5: ALU destination register.
- `a_data`, input, XLEN: ALU result.
- `a_ready`, output, 1: A accepted this cycle (combinational).
- `b_valid`, input, 1: load/divide writeback request.
- `b_rd`, input, 5: B destination register.
- `b_data`, input, XLEN: B result.
- `b_ready`, output, 1: B accepted this cycle (combinational).
- `wr_en`, output, 1: drives register file `regWrite`.
- `wr_reg`, output, 5: drives `writeReg`.
- `wr_data`, output, XLEN: drives `writeData`.
- `b_starving`, output, 1: high while the force state is active.
- `stat_a`, `stat_b`, `stat_conflict`, output, 32 each: present only with `REGFILE_WB_ARB_STATS_EN`.

## Operation
- Handshake: a transfer occurs on a port when its `valid` and `ready` are both high in the same cycle.
- Sources hold `rd` and `data` stable while `valid` is high and not yet accepted. `valid` is never dropped before acceptance.
- At most one of `a_ready`/`b_ready` is high in any cycle. `ready` is never high without the matching `valid`.
- FSM, 2 states:
  - `PRIO_A` (reset state):
    - If `a_valid`, grant A. Otherwise, if `b_valid`, grant B.
  - `FORCE_B`:
    - If `b_valid`, grant B; A is refused.
    - If `b_valid` is low, grant A if requested.
- Wait counter (4 bits):
  - Increments in any cycle where `b_valid` is high and `b_ready` is low, saturating at `MAX_WAIT`.
  - Clears to 0 on a B transfer or any cycle where `b_valid` is low.
- FSM transitions:
  - `PRIO_A` → `FORCE_B` on the edge where the counter reaches `MAX_WAIT`.
  - `FORCE_B` → `PRIO_A` on a B transfer or when `b_valid` is low.
- `b_starving` equals (state == `FORCE_B`).
- Output register:
  - On a transfer, load `wr_reg` = granted rd and `wr_data` = granted data next edge.
  - `wr_en` = 1, except when granted rd == 0, in which case `wr_en` = 0.
  - An x0 write still completes its handshake.
- No transfer: `wr_en` = 0 next cycle; `wr_reg`/`wr_data` hold their previous values.
- Same rd from A and B in consecutive cycles: writes reach the file in grant order. The later grant wins; no merging.

## Timing
- Grant decision is combinational from `valid` and state, with no bubble between back-to-back transfers.
- Latency from transfer edge to `wr_en`/`wr_reg`/`wr_data` visible at the file is 1 cycle. The file captures the write on the following edge.
- Sustained throughput is 1 write per cycle total.
- Worst-case B wait is `MAX_WAIT` + 1 cycles under continuous A traffic.
- Reset values:
  - `wr_en` = 0, `wr_reg` = 0, `wr_data` = 0.
  - State = `PRIO_A`, counter = 0, `b_starving` = 0, all stat counters = 0.
- During reset, `a_ready` = `b_ready` = 0.
- Reset asserted mid-starvation: the next cycle after deassertion is `PRIO_A` with counter 0. A write captured in the output register at the reset edge is discarded (`wr_en` = 0).

## Configuration
- `REGFILE_WB_ARB_STATS_EN` defined:
  - `stat_a`/`stat_b` increment on each A/B transfer (x0 included).
  - `stat_conflict` increments on each cycle with `a_valid` and `b_valid` both high.
  - All three wrap at 2^32 and clear on reset.
- Macro undefined: the three ports and their counters are absent; all other behaviour is identical.

## Test plan
- Lone A: `a_valid`=1, `a_rd`=5, `a_data`=0xDEAD → `a_ready`=1 same cycle; next cycle `wr_en`=1, `wr_reg`=5, `wr_data`=0xDEAD.
- Continuous A plus B waiting, `MAX_WAIT`=4 → B refused 4 cycles, `b_starving`=1 in cycle 5, `b_ready`=1 in cycle 5, `a_ready`=0 that cycle. `PRIO_A` resumes the next cycle.
- x0 write: `b_rd`=0, `b_data`=0x1234 → `b_ready`=1; next cycle `wr_en`=0.
- Back-to-back A to rd 7 (value 1) then B to rd 7 (value 2) → `wr_reg`=7 with `wr_data`=1, then 2, on consecutive cycles.
- `reset` pulsed while `b_starving`=1 with a pending output write → after reset, all outputs 0, state `PRIO_A`, counter 0.
- With `REGFILE_WB_ARB_STATS_EN`: 10 cycles of both-valid → `stat_conflict`=10, and `stat_a` + `stat_b` = 10.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback source and register-file write-port bundle
// master drives the two writeback requests; slave is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            wr_en;
  logic [4:0]      wr_reg;
  logic [XLEN-1:0] wr_data;
  logic            b_starving;
`ifdef REGFILE_WB_ARB_STATS_EN
  logic [31:0]     stat_a;
  logic [31:0]     stat_b;
  logic [31:0]     stat_conflict;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, wr_en, wr_reg, wr_data, b_starving,
    input  stat_a, stat_b, stat_conflict
  );
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, wr_en, wr_reg, wr_data, b_starving,
    output stat_a, stat_b, stat_conflict
  );
`else
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, wr_en, wr_reg, wr_data, b_starving
  );
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, wr_en, wr_reg, wr_data, b_starving
  );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source register-file write-port arbiter with B anti-starvation
// Optional transfer/conflict counters are built when REGFILE_WB_ARB_STATS_EN is defined.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = 64
) (
  input logic                  clk,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  bus
);

  typedef enum logic {PRIO_A, FORCE_B} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_wait;
  logic [3:0]      w_wait_nxt;
  logic            w_a_grant;
  logic            w_b_grant;
  logic            w_xfer;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_data;
  logic            r_wr_en;
  logic [4:0]      r_wr_reg;
  logic [XLEN-1:0] r_wr_data;

  always_comb begin
    w_a_grant   = 1'b0;
    w_b_grant   = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    if (!reset) begin
      case (r_state)
        PRIO_A: begin
          if (bus.a_valid)      w_a_grant = 1'b1;
          else if (bus.b_valid) w_b_grant = 1'b1;
        end
        FORCE_B: begin
          if (bus.b_valid)      w_b_grant = 1'b1;
          else if (bus.a_valid) w_a_grant = 1'b1;
        end
        default: ;
      endcase
    end
    if (!bus.b_valid || w_b_grant) w_wait_nxt = 4'd0;
    else if (r_wait != MAX_W)      w_wait_nxt = r_wait + 4'd1;
    // Counter hitting the limit implies B was just refused for the MAX_WAIT-th time.
    case (r_state)
      PRIO_A:  if (w_wait_nxt == MAX_W)           w_state_nxt = FORCE_B;
      FORCE_B: if (w_b_grant || !bus.b_valid)    w_state_nxt = PRIO_A;
      default: w_state_nxt = PRIO_A;
    endcase
  end

  assign w_xfer = w_a_grant | w_b_grant;
  assign w_rd   = w_b_grant ? bus.b_rd   : bus.a_rd;
  assign w_data = w_b_grant ? bus.b_data : bus.a_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= PRIO_A;
      r_wait    <= 4'd0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= 5'd0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_xfer) begin
        r_wr_en   <= (w_rd != 5'd0);
        r_wr_reg  <= w_rd;
        r_wr_data <= w_data;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign bus.a_ready    = w_a_grant;
  assign bus.b_ready    = w_b_grant;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_reg     = r_wr_reg;
  assign bus.wr_data    = r_wr_data;
  assign bus.b_starving = (r_state == FORCE_B);

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [31:0] r_stat_a;
  logic [31:0] r_stat_b;
  logic [31:0] r_stat_conflict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_a        <= 32'd0;
      r_stat_b        <= 32'd0;
      r_stat_conflict <= 32'd0;
    end else begin
      if (w_a_grant)                  r_stat_a        <= r_stat_a + 32'd1;
      if (w_b_grant)                  r_stat_b        <= r_stat_b + 32'd1;
      if (bus.a_valid && bus.b_valid) r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  assign bus.stat_a        = r_stat_a;
  assign bus.stat_b        = r_stat_b;
  assign bus.stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized bench for regfile_wb_arbiter
// Reference model: B is force-granted once it has been refused MAX_WAIT consecutive cycles.
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int XLEN     = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();
  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic        av, bv;
  logic [4:0]  ard, brd;
  logic [63:0] ad, bd;
  logic        a_acc, b_acc;

  int          m_wait;
  logic        m_wr_en;
  logic [4:0]  m_wr_reg;
  logic [63:0] m_wr_data;
  logic [31:0] m_sa, m_sb, m_sc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_wait    = 0;
    m_wr_en   = 1'b0;
    m_wr_reg  = 5'd0;
    m_wr_data = 64'd0;
    m_sa      = 32'd0;
    m_sb      = 32'd0;
    m_sc      = 32'd0;
  endtask

  // One clock cycle: apply inputs, check against model, then advance the model past the edge.
  task automatic step(input logic rst);
    logic ea, eb, starve;
    @(negedge clk);
    reset       = rst;
    bus.a_valid = av;  bus.a_rd = ard;  bus.a_data = ad;
    bus.b_valid = bv;  bus.b_rd = brd;  bus.b_data = bd;
    #1;
    starve = (m_wait >= MAX_WAIT);
    eb = !rst && bv && (!av || starve);
    ea = !rst && av && !eb;
    chk("a_ready",    bus.a_ready,    ea);
    chk("b_ready",    bus.b_ready,    eb);
    chk("b_starving", bus.b_starving, starve);
    chk("wr_en",      bus.wr_en,      m_wr_en);
    chk("wr_reg",     bus.wr_reg,     m_wr_reg);
    chk("wr_data",    bus.wr_data,    m_wr_data);
`ifdef REGFILE_WB_ARB_STATS_EN
    chk("stat_a",        bus.stat_a,        m_sa);
    chk("stat_b",        bus.stat_b,        m_sb);
    chk("stat_conflict", bus.stat_conflict, m_sc);
`endif
    a_acc = ea;
    b_acc = eb;
    if (rst) begin
      model_clear();
    end else begin
      if (ea || eb) begin
        m_wr_reg  = eb ? brd : ard;
        m_wr_data = eb ? bd : ad;
        m_wr_en   = (m_wr_reg != 5'd0);
      end else begin
        m_wr_en = 1'b0;
      end
      m_wait = (bv && !eb) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : m_wait) : 0;
      if (ea)      m_sa = m_sa + 32'd1;
      if (eb)      m_sb = m_sb + 32'd1;
      if (av && bv) m_sc = m_sc + 32'd1;
    end
  endtask

  // Sources drop valid only after acceptance, then may raise a fresh request.
  task automatic refresh(input int pa, input int pb);
    if (a_acc) av = 1'b0;
    if (b_acc) bv = 1'b0;
    if (!av && $urandom_range(0, 99) < pa) begin
      av = 1'b1; ard = 5'($urandom_range(0, 31)); ad = {$urandom(), $urandom()};
    end
    if (!bv && $urandom_range(0, 99) < pb) begin
      bv = 1'b1; brd = 5'($urandom_range(0, 31)); bd = {$urandom(), $urandom()};
    end
  endtask

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [31:0] s0_a, s0_b, s0_c;
`endif

  initial begin
    av = 0; bv = 0; ard = 0; brd = 0; ad = 0; bd = 0; a_acc = 0; b_acc = 0;
    reset = 1'b1;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    repeat (3) @(posedge clk);
    model_clear();

    // Requests held during reset must not be accepted.
    av = 1; ard = 5'd3; ad = 64'h33; bv = 1; brd = 5'd4; bd = 64'h44;
    step(1'b1);
    step(1'b1);
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_wr_en",   bus.wr_en,   1'b0);
    av = 0; bv = 0;
    step(1'b0);

    // Lone A
    av = 1; ard = 5'd5; ad = 64'hDEAD;
    step(1'b0);
    chk("lone_a_ready", bus.a_ready, 1'b1);
    av = 0;
    step(1'b0);
    chk("lone_a_wr_en",   bus.wr_en,   1'b1);
    chk("lone_a_wr_reg",  bus.wr_reg,  64'd5);
    chk("lone_a_wr_data", bus.wr_data, 64'hDEAD);

    // Continuous A starves B until the force cycle
    bv = 1; brd = 5'd9; bd = 64'h9999;
    for (int i = 1; i <= 4; i++) begin
      av = 1; ard = 5'(i + 1); ad = 64'(i);
      step(1'b0);
      chk("starve_b_refused", bus.b_ready, 1'b0);
    end
    av = 1; ard = 5'd10; ad = 64'hA0;
    step(1'b0);
    chk("starve_flag",   bus.b_starving, 1'b1);
    chk("starve_b_ok",   bus.b_ready,    1'b1);
    chk("starve_a_held", bus.a_ready,    1'b0);
    bv = 0;
    step(1'b0);
    chk("starve_exit", bus.b_starving, 1'b0);
    chk("starve_a_ok", bus.a_ready,    1'b1);
    av = 0;
    step(1'b0);

    // x0 write completes the handshake but does not write
    bv = 1; brd = 5'd0; bd = 64'h1234;
    step(1'b0);
    chk("x0_b_ready", bus.b_ready, 1'b1);
    bv = 0;
    step(1'b0);
    chk("x0_wr_en", bus.wr_en, 1'b0);

    // Same rd from A then B: grant order preserved
    av = 1; ard = 5'd7; ad = 64'd1;
    step(1'b0);
    av = 0; bv = 1; brd = 5'd7; bd = 64'd2;
    step(1'b0);
    chk("order_first_reg",  bus.wr_reg,  64'd7);
    chk("order_first_data", bus.wr_data, 64'd1);
    bv = 0;
    step(1'b0);
    chk("order_second_reg",  bus.wr_reg,  64'd7);
    chk("order_second_data", bus.wr_data, 64'd2);

    // Reset in the force cycle with a pending output write
    bv = 1; brd = 5'd12; bd = 64'hC0C0;
    for (int i = 0; i < 4; i++) begin
      av = 1; ard = 5'(20 + i); ad = 64'(100 + i);
      step(1'b0);
    end
    av = 1; ard = 5'd13; ad = 64'h55;
    step(1'b1);
    chk("rst_mid_starving", bus.b_starving, 1'b1);
    chk("rst_mid_pending",  bus.wr_en,      1'b1);
    step(1'b0);
    chk("post_rst_wr_en",    bus.wr_en,      1'b0);
    chk("post_rst_wr_reg",   bus.wr_reg,     64'd0);
    chk("post_rst_wr_data",  bus.wr_data,    64'd0);
    chk("post_rst_starving", bus.b_starving, 1'b0);
    chk("post_rst_a_ready",  bus.a_ready,    1'b1);

`ifdef REGFILE_WB_ARB_STATS_EN
    // Ten cycles with both sources requesting
    for (int i = 0; i < 10; i++) begin
      refresh(100, 100);
      step(1'b0);
      if (i == 0) begin
        s0_a = bus.stat_a; s0_b = bus.stat_b; s0_c = bus.stat_conflict;
      end
    end
    refresh(0, 0);
    av = 0; bv = 0;
    step(1'b0);
    chk("stats_conflict", bus.stat_conflict - s0_c, 32'd10);
    chk("stats_a_plus_b", (bus.stat_a - s0_a) + (bus.stat_b - s0_b), 32'd10);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      refresh(70, 45);
      step($urandom_range(0, 99) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
